// File: rtl/prog_counter_pkg.sv
// Shared encodings for the programmable counter: controller states,
// count direction and terminal behaviour.
package prog_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
    localparam logic DIR_DOWN     = 1'b0;
    localparam logic DIR_UP       = 1'b1;

endpackage

// File: rtl/prog_counter_if.sv
// Control and status bundle between a sequencer (master) and the
// programmable counter (slave).
interface prog_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] limit;
    logic             dir;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output enable, start, stop, load, load_value, limit, dir, mode,
        input  count, busy, tc, done
    );

    modport slave (
        input  enable, start, stop, load, load_value, limit, dir, mode,
        output count, busy, tc, done
    );
endinterface

// File: rtl/prog_counter.sv
// Programmable up/down counter with run/done handshake, clamped terminal
// value, wrap or one-shot operation, synchronous load and abort.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 255
) (
    input logic           clk,
    input logic           reset,
    prog_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             dir_q, dir_d;
    logic             mode_q, mode_d;

    logic [WIDTH-1:0] limit_clamped;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] start_value;
    logic             at_term;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] value,
                                               input logic [WIDTH-1:0] ceiling);
        return (value > ceiling) ? ceiling : value;
    endfunction

    assign limit_clamped = clamp(bus.limit, MAX_VAL);
    assign term          = (dir_q == DIR_UP) ? lim_q : '0;
    assign start_value   = (dir_q == DIR_UP) ? '0 : lim_q;
    assign at_term       = (count_q == term);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            lim_q   <= '0;
            dir_q   <= DIR_DOWN;
            mode_q  <= MODE_WRAP;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    // Branch order inside each state encodes the priority stop > load > start > enable.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lim_d   = lim_q;
        dir_d   = dir_q;
        mode_d  = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    count_d = clamp(bus.load_value, MAX_VAL);
                end else if (bus.start) begin
                    state_d = ST_RUN;
                    lim_d   = limit_clamped;
                    dir_d   = bus.dir;
                    mode_d  = bus.mode;
                    count_d = (bus.dir == DIR_UP) ? '0 : limit_clamped;
                end
            end

            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.load) begin
                    count_d = clamp(bus.load_value, lim_q);
                end else if (bus.enable) begin
                    if (!at_term) begin
                        count_d = (dir_q == DIR_UP) ? count_q + ONE : count_q - ONE;
                    end else if (mode_q == MODE_ONESHOT) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = start_value;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.load) begin
                    count_d = clamp(bus.load_value, lim_q);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.count = count_q;
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.tc    = (state_q == ST_RUN) && at_term;
    assign bus.done  = (state_q == ST_DONE);

endmodule
